ace_snoop_initiator: RTL and testbench

- Interconnect-side initiator for the ACE snoop channels (AC out; CR and CD in), i.e. the opposite end of a cached master's snoop port.
- Accepts one snoop command at a time from the coherency controller and drives it on AC.
- Collects the CR response and any CD cache-line data, then returns one assembled result: response bits, full line, error flag.
- Sits in the CCU, one instance per snooped master.

---
 rtl/ace_snoop_initiator.sv | 201 ++++++++++++++++++++
 tb/tb_ace_snoop_initiator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_initiator.sv
// ace_snoop_initiator: interconnect-side initiator for the ACE snoop channels.
// Issues one snoop on AC, collects CR and CD (in any order), and returns the
// captured response, assembled cache line and error flags as a single result.
// Optional watchdog enabled by defining SNOOP_TIMEOUT_EN.
module ace_snoop_initiator #(
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned LineBeats     = 2,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [AddrWidth-1:0]           req_addr_i,
    input  logic [3:0]                     req_snoop_i,
    input  logic [2:0]                     req_prot_i,
    output logic                           ac_valid_o,
    input  logic                           ac_ready_i,
    output logic [AddrWidth-1:0]           ac_addr_o,
    output logic [3:0]                     ac_snoop_o,
    output logic [2:0]                     ac_prot_o,
    input  logic                           cr_valid_i,
    output logic                           cr_ready_o,
    input  logic [4:0]                     cr_resp_i,
    input  logic                           cd_valid_i,
    output logic                           cd_ready_o,
    input  logic [DataWidth-1:0]           cd_data_i,
    input  logic                           cd_last_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [4:0]                     rsp_cr_o,
    output logic [LineBeats*DataWidth-1:0] rsp_line_o,
    output logic                           rsp_err_o,
    output logic                           rsp_timeout_o
);

    localparam int unsigned CntW = $clog2(LineBeats);
    localparam logic [CntW-1:0] LastBeat = CntW'(LineBeats - 1);

    typedef enum logic [1:0] {IDLE, AC, WAIT, RSP} state_e;

    state_e                         state_q, state_d;
    logic [AddrWidth-1:0]           addr_q, addr_d;
    logic [3:0]                     snoop_q, snoop_d;
    logic [2:0]                     prot_q, prot_d;
    logic [4:0]                     cr_q, cr_d;
    logic [LineBeats*DataWidth-1:0] line_q, line_d;
    logic [CntW-1:0]                cnt_q, cnt_d;
    logic                           cr_done_q, cr_done_d;
    logic                           cd_done_q, cd_done_d;
    logic                           ovf_q, ovf_d;
    logic                           err_q, err_d;
    logic                           any_beat;

    // Handshake signals decode straight from state; req_ready is held low while reset is asserted.
    assign req_ready_o = (state_q == IDLE) && rst_ni;
    assign ac_valid_o  = (state_q == AC);
    assign cr_ready_o  = (state_q == WAIT) && !cr_done_q;
    assign cd_ready_o  = (state_q == WAIT) && !cd_done_q;
    assign rsp_valid_o = (state_q == RSP);
    assign ac_addr_o   = addr_q;
    assign ac_snoop_o  = snoop_q;
    assign ac_prot_o   = prot_q;
    assign rsp_cr_o    = cr_q;
    assign rsp_line_o  = line_q;
    assign rsp_err_o   = err_q;

`ifdef SNOOP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout_q, timeout_d;
    assign rsp_timeout_o = timeout_q;
`else
    // Parameter is only meaningful with the watchdog; fold it away here.
    logic unused_timeout;
    assign unused_timeout = ^TimeoutCycles;
    assign rsp_timeout_o  = 1'b0;
`endif

    // Next-state, payload capture and line assembly.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        snoop_d   = snoop_q;
        prot_d    = prot_q;
        cr_d      = cr_q;
        line_d    = line_q;
        cnt_d     = cnt_q;
        cr_done_d = cr_done_q;
        cd_done_d = cd_done_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        any_beat  = 1'b0;
`ifdef SNOOP_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d    = req_addr_i;
                    snoop_d   = req_snoop_i;
                    prot_d    = req_prot_i;
                    cr_d      = '0;
                    line_d    = '0;
                    cnt_d     = '0;
                    cr_done_d = 1'b0;
                    cd_done_d = 1'b0;
                    ovf_d     = 1'b0;
                    err_d     = 1'b0;
`ifdef SNOOP_TIMEOUT_EN
                    tcnt_d    = '0;
                    timeout_d = 1'b0;
`endif
                    state_d   = AC;
                end
            end
            AC: begin
                if (ac_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (cr_valid_i && cr_ready_o) begin
                    cr_d      = cr_resp_i;
                    cr_done_d = 1'b1;
                end
                if (cd_valid_i && cd_ready_o) begin
                    // Beats past the end of the line are consumed but never stored.
                    if (!ovf_q) line_d[cnt_q*DataWidth +: DataWidth] = cd_data_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cd_last_i) begin
                        cd_done_d = 1'b1;
                        if (cnt_q != LastBeat) err_d = 1'b1;
                    end else if (cnt_q == LastBeat) begin
                        err_d = 1'b1;
                        ovf_d = 1'b1;
                    end
                end
                // Exit decision uses this cycle's handshakes so a same-cycle CR/CD completes next cycle.
                any_beat = (cnt_d != '0) || ovf_d || cd_done_d;
                if (cr_done_d && !cr_d[0] && any_beat) err_d = 1'b1;
                if (cr_done_d && (cd_done_d || (!cr_d[0] && !any_beat))) state_d = RSP;
            end
            RSP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef SNOOP_TIMEOUT_EN
        // Watchdog overrides any normal completion in the same cycle.
        if (state_q == AC || state_q == WAIT) begin
            tcnt_d = tcnt_q + 1'b1;
            if (tcnt_d == TW'(TimeoutCycles)) begin
                state_d   = RSP;
                timeout_d = 1'b1;
                err_d     = 1'b1;
                cr_d      = '0;
                line_d    = '0;
            end
        end
`endif
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            snoop_q   <= '0;
            prot_q    <= '0;
            cr_q      <= '0;
            line_q    <= '0;
            cnt_q     <= '0;
            cr_done_q <= 1'b0;
            cd_done_q <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            snoop_q   <= snoop_d;
            prot_q    <= prot_d;
            cr_q      <= cr_d;
            line_q    <= line_d;
            cnt_q     <= cnt_d;
            cr_done_q <= cr_done_d;
            cd_done_q <= cd_done_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
`ifdef SNOOP_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Directed bench for ace_snoop_initiator with a result scoreboard.
module tb_ace_snoop_initiator;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         req_valid_i, req_ready_o;
    logic [63:0]  req_addr_i;
    logic [3:0]   req_snoop_i;
    logic [2:0]   req_prot_i;
    logic         ac_valid_o, ac_ready_i;
    logic [63:0]  ac_addr_o;
    logic [3:0]   ac_snoop_o;
    logic [2:0]   ac_prot_o;
    logic         cr_valid_i, cr_ready_o;
    logic [4:0]   cr_resp_i;
    logic         cd_valid_i, cd_ready_o;
    logic [63:0]  cd_data_i;
    logic         cd_last_i;
    logic         rsp_valid_o, rsp_ready_i;
    logic [4:0]   rsp_cr_o;
    logic [127:0] rsp_line_o;
    logic         rsp_err_o, rsp_timeout_o;

    typedef struct {
        logic [4:0]   cr;
        logic [127:0] line;
        logic         err;
        logic         to;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk_i = ~clk_i;

    ace_snoop_initiator #(
        .AddrWidth(64), .DataWidth(64), .LineBeats(2), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_snoop_i(req_snoop_i), .req_prot_i(req_prot_i),
        .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o),
        .ac_snoop_o(ac_snoop_o), .ac_prot_o(ac_prot_o),
        .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
        .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i), .cd_last_i(cd_last_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_cr_o(rsp_cr_o),
        .rsp_line_o(rsp_line_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 128'({req_ready_o, ac_valid_o, cr_ready_o, cd_ready_o, rsp_valid_o,
                                 rsp_err_o, rsp_timeout_o, rsp_cr_o}), '0);
        chk({tag, "_ac"}, 128'({ac_addr_o, ac_snoop_o, ac_prot_o}), '0);
        chk({tag, "_line"}, rsp_line_o, '0);
    endtask

    task automatic send_req(input logic [63:0] a, input logic [3:0] s, input logic [2:0] p);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_snoop_i = s;
        req_prot_i  = p;
        chk("req_ready", 128'(req_ready_o), 128'(1));
        tick();
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        chk("ac_valid_first", 128'(ac_valid_o), 128'(1));
        chk("ac_payload", 128'({ac_addr_o, ac_snoop_o, ac_prot_o}), 128'({a, s, p}));
    endtask

    task automatic ac_hs();
        ac_ready_i = 1'b1;
        tick();
        ac_ready_i = 1'b0;
    endtask

    task automatic finish_rsp();
        int   n = 0;
        exp_t e;
        while (!rsp_valid_o && n < 64) begin
            tick();
            n++;
        end
        chk("rsp_valid", 128'(rsp_valid_o), 128'(1));
        chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_cr", 128'(rsp_cr_o), 128'(e.cr));
            chk("rsp_line", rsp_line_o, e.line);
            chk("rsp_err", 128'(rsp_err_o), 128'(e.err));
            chk("rsp_timeout", 128'(rsp_timeout_o), 128'(e.to));
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("rsp_drop", 128'(rsp_valid_o), 128'(0));
        chk("idle_ready", 128'(req_ready_o), 128'(1));
    endtask

    task automatic beat(input logic [63:0] d, input logic last);
        cd_valid_i = 1'b1;
        cd_data_i  = d;
        cd_last_i  = last;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_snoop_i = '0; req_prot_i = '0;
        ac_ready_i = 1'b0; cr_valid_i = 1'b0; cr_resp_i = '0; cd_valid_i = 1'b0;
        cd_data_i = '0; cd_last_i = 1'b0; rsp_ready_i = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        rst_ni = 1'b1;
        tick();
        chk("post_reset_ready", 128'(req_ready_o), 128'(1));

        // ReadShared: CR at t2 with first beat, last beat next cycle.
        sb.push_back('{cr: 5'h09, line: {64'h2222, 64'h1111}, err: 1'b0, to: 1'b0});
        send_req(64'h8000_0040, 4'b0001, 3'b010);
        ac_hs();
        chk("wait_readies", 128'({cr_ready_o, cd_ready_o}), 128'(2'b11));
        cr_valid_i = 1'b1; cr_resp_i = 5'b01001;
        beat(64'h1111, 1'b0);
        tick();
        cr_valid_i = 1'b0;
        chk("cr_ready_drop", 128'(cr_ready_o), 128'(0));
        beat(64'h2222, 1'b1);
        tick();
        cd_valid_i = 1'b0; cd_last_i = 1'b0;
        chk("t1_rsp_after_last", 128'(rsp_valid_o), 128'(1));
        finish_rsp();

        // CleanInvalid, no data: minimum latency t3.
        sb.push_back('{cr: 5'h00, line: '0, err: 1'b0, to: 1'b0});
        send_req(64'h1234_5678_9ABC_DE00, 4'b1001, 3'b000);
        ac_hs();
        cr_valid_i = 1'b1; cr_resp_i = 5'b00000;
        tick();
        cr_valid_i = 1'b0;
        chk("t2_rsp_at_t3", 128'(rsp_valid_o), 128'(1));
        finish_rsp();

        // AC stalled four cycles, then CD three cycles ahead of CR.
        sb.push_back('{cr: 5'h11, line: {64'hCAFE_0000_0000_00B1, 64'hCAFE_0000_0000_00B0}, err: 1'b0, to: 1'b0});
        send_req(64'h0000_0000_FFFF_FFC0, 4'b0111, 3'b101);
        for (int i = 0; i < 4; i++) begin
            chk("ac_stall", 128'({ac_valid_o, ac_addr_o, ac_snoop_o, ac_prot_o}),
                128'({1'b1, 64'h0000_0000_FFFF_FFC0, 4'b0111, 3'b101}));
            tick();
        end
        ac_hs();
        beat(64'hCAFE_0000_0000_00B0, 1'b0);
        tick();
        beat(64'hCAFE_0000_0000_00B1, 1'b1);
        tick();
        cd_valid_i = 1'b0; cd_last_i = 1'b0;
        tick();
        chk("t3_cd_done_hold", 128'({rsp_valid_o, cd_ready_o, cr_ready_o}), 128'(3'b001));
        cr_valid_i = 1'b1; cr_resp_i = 5'b10001;
        tick();
        cr_valid_i = 1'b0;
        chk("t3_rsp_after_cr", 128'(rsp_valid_o), 128'(1));
        finish_rsp();

        // Early last: single beat with last flagged.
        sb.push_back('{cr: 5'h01, line: {64'h0, 64'hAAAA}, err: 1'b1, to: 1'b0});
        send_req(64'h40, 4'b0001, 3'b000);
        ac_hs();
        cr_valid_i = 1'b1; cr_resp_i = 5'b00001;
        tick();
        cr_valid_i = 1'b0;
        beat(64'hAAAA, 1'b1);
        tick();
        cd_valid_i = 1'b0; cd_last_i = 1'b0;
        finish_rsp();

        // Overrun: no last on final slot, extra beat discarded.
        sb.push_back('{cr: 5'h03, line: {64'hC1, 64'hC0}, err: 1'b1, to: 1'b0});
        send_req(64'h80, 4'b0001, 3'b001);
        ac_hs();
        cr_valid_i = 1'b1; cr_resp_i = 5'b00011;
        beat(64'hC0, 1'b0);
        tick();
        cr_valid_i = 1'b0;
        beat(64'hC1, 1'b0);
        tick();
        chk("ovf_not_done", 128'(rsp_valid_o), 128'(0));
        beat(64'hC2, 1'b1);
        tick();
        cd_valid_i = 1'b0; cd_last_i = 1'b0;
        chk("ovf_rsp", 128'(rsp_valid_o), 128'(1));
        finish_rsp();

        // DataTransfer=0 but data sent: error, waits for last beat.
        sb.push_back('{cr: 5'h00, line: {64'hD1, 64'hD0}, err: 1'b1, to: 1'b0});
        send_req(64'hC0, 4'b1000, 3'b000);
        ac_hs();
        beat(64'hD0, 1'b0);
        tick();
        cr_valid_i = 1'b1; cr_resp_i = 5'b00000;
        beat(64'hD1, 1'b1);
        tick();
        cr_valid_i = 1'b0; cd_valid_i = 1'b0; cd_last_i = 1'b0;
        chk("dt0_rsp", 128'(rsp_valid_o), 128'(1));
        finish_rsp();

        // Result back-pressure with a new request pending.
        sb.push_back('{cr: 5'h04, line: '0, err: 1'b0, to: 1'b0});
        send_req(64'h100, 4'b1001, 3'b000);
        ac_hs();
        cr_valid_i = 1'b1; cr_resp_i = 5'b00100;
        tick();
        cr_valid_i = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 64'h200;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", 128'({req_ready_o, rsp_valid_o, rsp_cr_o, rsp_err_o}), 128'({1'b0, 1'b1, 5'h04, 1'b0}));
            tick();
        end
        req_valid_i = 1'b0; req_addr_i = '0;
        finish_rsp();

        // Reset in the middle of WAIT after one beat.
        send_req(64'h300, 4'b0001, 3'b111);
        ac_hs();
        beat(64'h5555, 1'b0);
        tick();
        cd_valid_i = 1'b0;
        rst_ni = 1'b0;
        tick();
        chk_zero("midreset");
        rst_ni = 1'b1;
        tick();
        chk("midreset_idle", 128'(req_ready_o), 128'(1));

`ifdef SNOOP_TIMEOUT_EN
        // CR never returned: watchdog fires 16 cycles after acceptance.
        begin
            int n = 0;
            sb.push_back('{cr: 5'h00, line: '0, err: 1'b1, to: 1'b1});
            send_req(64'h400, 4'b0001, 3'b000);
            ac_hs();
            n = 1;
            while (!rsp_valid_o && n < 64) begin
                beat(64'h7777, 1'b0);
                tick();
                n++;
            end
            cd_valid_i = 1'b0;
            chk("to_latency", 128'(n), 128'(16));
            chk("to_readies", 128'({cr_ready_o, cd_ready_o}), '0);
            finish_rsp();
        end
`endif

        chk("sb_drained", 128'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
